// File: rtl/hc_sr_scheduler.sv
// hc_sr_scheduler
//   Round-robin sequencer that shares one trigger/echo timing datapath among
//   NUM_SENS HC-SR ultrasonic sensors. Each slot triggers one sensor, times
//   its echo pulse in whole microseconds, reports one status-coded result,
//   then waits a guard interval before moving on to the next sensor.
//
// Ports
//   Clk         system clock
//   Rst         synchronous reset, active-high
//   en          1 = scan continuously, 0 = finish the current slot then idle
//   echo        raw echo pins (asynchronous), one per sensor
//   trig        trigger pins, one-hot while triggering, otherwise all zero
//   busy        high in every state except IDLE
//   meas_valid  one-cycle result strobe
//   meas_id     sensor index of the result
//   meas_us     echo high time in whole microseconds
//   meas_err    0 ok, 1 no echo, 2 overrange, 3 echo stuck high at slot start
module hc_sr_scheduler #(
  parameter int  CLK_FREQ    = 50_000_000,
  parameter int  NUM_SENS    = 4,
  parameter int  TRIG_US     = 10,
  parameter int  RISE_TO_US  = 1000,
  parameter int  ECHO_MAX_US = 38000,
  parameter int  GUARD_US    = 60000,
  localparam int IDW         = $clog2(NUM_SENS)
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                en,
  input  logic [NUM_SENS-1:0] echo,
  output logic [NUM_SENS-1:0] trig,
  output logic                busy,
  output logic                meas_valid,
  output logic [IDW-1:0]      meas_id,
  output logic [15:0]         meas_us,
  output logic [1:0]          meas_err
);

  localparam int DIV = CLK_FREQ / 1_000_000;
  localparam int PW  = $clog2(DIV);

  localparam logic [PW-1:0]  PRE_LAST   = PW'(DIV - 1);
  localparam logic [15:0]    TRIG_LAST  = 16'(TRIG_US - 1);
  localparam logic [15:0]    RISE_LAST  = 16'(RISE_TO_US - 1);
  localparam logic [15:0]    ECHO_LAST  = 16'(ECHO_MAX_US - 1);
  localparam logic [15:0]    ECHO_MAX   = 16'(ECHO_MAX_US);
  localparam logic [15:0]    GUARD_LAST = 16'(GUARD_US - 1);
  localparam logic [IDW-1:0] IDX_LAST   = IDW'(NUM_SENS - 1);

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_NO_ECHO  = 2'd1;
  localparam logic [1:0] ERR_OVERRNG  = 2'd2;
  localparam logic [1:0] ERR_STUCK    = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_GUARD
  } state_t;

  state_t              state;
  logic [IDW-1:0]      idx;
  logic [PW-1:0]       pre_cnt;
  logic [15:0]         us_cnt;
  logic                stuck;
  logic [NUM_SENS-1:0] echo_meta;
  logic [NUM_SENS-1:0] echo_sync;

  logic                tick;
  logic                echo_cur;
  logic [IDW-1:0]      idx_next;

  function automatic logic [NUM_SENS-1:0] onehot(input logic [IDW-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  // Two-flop synchroniser on every echo pin; edges reach the FSM 2 cycles late.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      echo_meta <= '0;
      echo_sync <= '0;
    end else begin
      echo_meta <= echo;
      echo_sync <= echo_meta;
    end
  end

  assign tick     = (pre_cnt == PRE_LAST);
  assign echo_cur = echo_sync[idx];
  assign idx_next = (idx == IDX_LAST) ? '0 : idx + IDW'(1);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      pre_cnt    <= '0;
      us_cnt     <= '0;
      stuck      <= 1'b0;
      trig       <= '0;
      busy       <= 1'b0;
      meas_valid <= 1'b0;
      meas_id    <= '0;
      meas_us    <= '0;
      meas_err   <= ERR_OK;
    end else begin
      // NOTE: these are defaults; a later non-blocking assignment in the same
      // cycle (e.g. a counter restart on a state change) takes precedence.
      meas_valid <= 1'b0;
      pre_cnt    <= tick ? '0 : pre_cnt + PW'(1);
      // The microsecond counter only accumulates echo-high time in MEASURE.
      if (tick && (state != S_MEASURE || echo_cur)) begin
        us_cnt <= us_cnt + 16'd1;
      end

      case (state)
        S_IDLE: begin
          pre_cnt <= '0;
          us_cnt  <= '0;
          if (en) begin
            state <= S_TRIG;
            busy  <= 1'b1;
            // An echo already high before triggering cannot be measured.
            stuck <= echo_sync[idx];
            trig  <= echo_sync[idx] ? '0 : onehot(idx);
          end
        end

        S_TRIG: begin
          if (stuck) begin
            meas_valid <= 1'b1;
            meas_id    <= idx;
            meas_us    <= '0;
            meas_err   <= ERR_STUCK;
            state      <= S_GUARD;
            pre_cnt    <= '0;
            us_cnt     <= '0;
          end else if (tick && us_cnt == TRIG_LAST) begin
            trig    <= '0;
            state   <= S_WAIT_RISE;
            pre_cnt <= '0;
            us_cnt  <= '0;
          end
        end

        S_WAIT_RISE: begin
          if (echo_cur) begin
            state   <= S_MEASURE;
            pre_cnt <= '0;
            us_cnt  <= '0;
          end else if (tick && us_cnt == RISE_LAST) begin
            meas_valid <= 1'b1;
            meas_id    <= idx;
            meas_us    <= '0;
            meas_err   <= ERR_NO_ECHO;
            state      <= S_GUARD;
            pre_cnt    <= '0;
            us_cnt     <= '0;
          end
        end

        S_MEASURE: begin
          if (!echo_cur) begin
            // Partial microsecond since the last tick is truncated.
            meas_valid <= 1'b1;
            meas_id    <= idx;
            meas_us    <= us_cnt;
            meas_err   <= ERR_OK;
            state      <= S_GUARD;
            pre_cnt    <= '0;
            us_cnt     <= '0;
          end else if (tick && us_cnt == ECHO_LAST) begin
            meas_valid <= 1'b1;
            meas_id    <= idx;
            meas_us    <= ECHO_MAX;
            meas_err   <= ERR_OVERRNG;
            state      <= S_GUARD;
            pre_cnt    <= '0;
            us_cnt     <= '0;
          end
        end

        S_GUARD: begin
          if (tick && us_cnt == GUARD_LAST) begin
            idx     <= idx_next;
            pre_cnt <= '0;
            us_cnt  <= '0;
            if (en) begin
              state <= S_TRIG;
              stuck <= echo_sync[idx_next];
              trig  <= echo_sync[idx_next] ? '0 : onehot(idx_next);
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state <= S_IDLE;
          trig  <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hc_sr_scheduler.sv
// tb_hc_sr_scheduler
//   Directed bench for hc_sr_scheduler with DIV = 4, two sensors,
//   TRIG_US = 10, RISE_TO_US = 20, ECHO_MAX_US = 100, GUARD_US = 30.
//   Inputs are driven and outputs sampled 1 time unit after the falling edge.
module tb_hc_sr_scheduler;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        en;
  logic [1:0]  echo;
  logic [1:0]  trig;
  logic        busy;
  logic        meas_valid;
  logic [0:0]  meas_id;
  logic [15:0] meas_us;
  logic [1:0]  meas_err;

  int n_pass  = 0;
  int n_total = 0;

  hc_sr_scheduler #(
    .CLK_FREQ   (4_000_000),
    .NUM_SENS   (2),
    .TRIG_US    (10),
    .RISE_TO_US (20),
    .ECHO_MAX_US(100),
    .GUARD_US   (30)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .en        (en),
    .echo      (echo),
    .trig      (trig),
    .busy      (busy),
    .meas_valid(meas_valid),
    .meas_id   (meas_id),
    .meas_us   (meas_us),
    .meas_err  (meas_err)
  );

  always #5 Clk = ~Clk;

  // Event monitor: cycle stamps of trig edges, strobes and busy falling.
  int          cyc = 0;
  int          mv_count = 0;
  int          mv_cyc = 0;
  logic [0:0]  mv_id = '0;
  logic [15:0] mv_us = '0;
  logic [1:0]  mv_err = '0;
  int          rise_count [2] = '{0, 0};
  int          fall_count [2] = '{0, 0};
  int          rise_cyc [2]   = '{0, 0};
  int          hi_len [2]     = '{0, 0};
  int          busy_fall_cyc = 0;
  int          multi_cnt = 0;
  logic [1:0]  trig_q = '0;
  logic        busy_q = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (meas_valid === 1'b1) begin
      mv_count++;
      mv_cyc = cyc;
      mv_id  = meas_id;
      mv_us  = meas_us;
      mv_err = meas_err;
    end
    for (int s = 0; s < 2; s++) begin
      if (trig[s] === 1'b1 && !trig_q[s]) begin
        rise_count[s]++;
        rise_cyc[s] = cyc;
      end
      if (trig[s] === 1'b0 && trig_q[s]) begin
        fall_count[s]++;
        hi_len[s] = cyc - rise_cyc[s];
      end
    end
    if (busy_q && busy === 1'b0) busy_fall_cyc = cyc;
    if (trig === 2'b11) multi_cnt++;
    trig_q = (trig === 2'bxx) ? 2'b00 : trig;
    busy_q = (busy === 1'b1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge Clk);
      #1;
    end
  endtask

  task automatic wait_rise(input int s, input int budget, output bit ok);
    int start;
    start = rise_count[s];
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      step(1);
      if (rise_count[s] != start) ok = 1'b1;
    end
  endtask

  task automatic wait_fall(input int s, input int budget, output bit ok);
    int start;
    start = fall_count[s];
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      step(1);
      if (fall_count[s] != start) ok = 1'b1;
    end
  endtask

  task automatic wait_mv(input int budget, output bit ok);
    int start;
    start = mv_count;
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      step(1);
      if (mv_count != start) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      step(1);
      if (busy === 1'b0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1; en = 1'b0; echo = 2'b00;
    step(3);
    n_total++; if (trig !== 2'b00) $display("FAIL reset_trig: got %b want 00", trig); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (meas_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", meas_valid); else n_pass++;
    n_total++; if ({meas_id, meas_us, meas_err} !== 19'd0)
      $display("FAIL reset_result: got id=%0d us=%0d err=%0d want 0/0/0", meas_id, meas_us, meas_err); else n_pass++;
    Rst = 1'b0;
    step(5);
    n_total++; if (busy !== 1'b0 || trig !== 2'b00)
      $display("FAIL idle_en_low: got busy=%b trig=%b want 0/00", busy, trig); else n_pass++;
  endtask

  task automatic test_normal();
    bit ok;
    int start;
    start = mv_count;
    en = 1'b1;
    wait_rise(0, 10, ok);
    n_total++; if (!ok) $display("FAIL normal_trig0_rise: got timeout want trig[0] rise"); else n_pass++;
    wait_fall(0, 100, ok);
    n_total++; if (!ok || hi_len[0] != 40)
      $display("FAIL normal_trig_width: got %0d cycles want 40", hi_len[0]); else n_pass++;
    step(20);
    echo[0] = 1'b1;
    step(148);
    echo[0] = 1'b0;
    wait_mv(50, ok);
    n_total++; if (!ok || mv_id !== 1'b0 || mv_err !== 2'd0)
      $display("FAIL normal_result: got ok=%0d id=%0d err=%0d want 1/0/0", ok, mv_id, mv_err); else n_pass++;
    n_total++; if (mv_us < 16'd36 || mv_us > 16'd38)
      $display("FAIL normal_us: got %0d want 36..38", mv_us); else n_pass++;
    n_total++; if (mv_count - start != 1 || busy !== 1'b1)
      $display("FAIL normal_one_strobe: got %0d strobes busy=%b want 1/1", mv_count - start, busy); else n_pass++;
  endtask

  task automatic test_no_echo();
    bit ok;
    int fall_at;
    wait_rise(1, 200, ok);
    n_total++; if (!ok) $display("FAIL noecho_trig1_rise: got timeout want trig[1] rise"); else n_pass++;
    wait_fall(1, 100, ok);
    fall_at = cyc;
    wait_mv(200, ok);
    n_total++; if (!ok || mv_cyc - fall_at != 80)
      $display("FAIL noecho_latency: got %0d cycles want 80", mv_cyc - fall_at); else n_pass++;
    n_total++; if (mv_id !== 1'b1 || mv_err !== 2'd1)
      $display("FAIL noecho_result: got id=%0d err=%0d want 1/1", mv_id, mv_err); else n_pass++;
    wait_rise(0, 200, ok);
    n_total++; if (!ok || rise_cyc[0] - mv_cyc != 120)
      $display("FAIL noecho_guard: got %0d cycles want 120", rise_cyc[0] - mv_cyc); else n_pass++;
  endtask

  // Leaves echo[0] high so the following slot on sensor 0 starts stuck.
  task automatic test_overrange(output int r0);
    bit ok;
    wait_fall(0, 100, ok);
    step(20);
    echo[0] = 1'b1;
    wait_mv(900, ok);
    n_total++; if (!ok || mv_err !== 2'd2 || mv_us !== 16'd100 || mv_id !== 1'b0)
      $display("FAIL overrange_result: got id=%0d us=%0d err=%0d want 0/100/2", mv_id, mv_us, mv_err); else n_pass++;
    r0 = rise_count[0];
    wait_rise(1, 200, ok);
    n_total++; if (!ok || rise_cyc[1] - mv_cyc != 120 || rise_count[0] != r0)
      $display("FAIL overrange_guard: got %0d cycles extra_trig0=%0d want 120/0",
               rise_cyc[1] - mv_cyc, rise_count[0] - r0); else n_pass++;
  endtask

  task automatic test_stuck(input int r0);
    bit ok;
    wait_mv(300, ok);
    n_total++; if (!ok || mv_id !== 1'b1 || mv_err !== 2'd1)
      $display("FAIL other_echo_ignored: got id=%0d err=%0d want 1/1", mv_id, mv_err); else n_pass++;
    wait_mv(300, ok);
    n_total++; if (!ok || mv_id !== 1'b0 || mv_err !== 2'd3)
      $display("FAIL stuck_result: got id=%0d err=%0d want 0/3", mv_id, mv_err); else n_pass++;
    n_total++; if (rise_count[0] != r0)
      $display("FAIL stuck_no_trig: got %0d trig[0] pulses want 0", rise_count[0] - r0); else n_pass++;
    echo[0] = 1'b0;
    wait_rise(1, 300, ok);
    n_total++; if (!ok) $display("FAIL stuck_next_sensor: got timeout want trig[1] rise"); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    wait_fall(1, 100, ok);
    step(8);
    echo[1] = 1'b1;
    step(40);
    echo[1] = 1'b0;
    wait_mv(50, ok);
    n_total++; if (!ok || mv_id !== 1'b1 || mv_err !== 2'd0 || mv_us < 16'd9 || mv_us > 16'd11)
      $display("FAIL short_echo: got id=%0d us=%0d err=%0d want 1/9..11/0", mv_id, mv_us, mv_err); else n_pass++;
  endtask

  task automatic test_en_drop();
    bit ok;
    int r1;
    wait_rise(0, 200, ok);
    wait_fall(0, 100, ok);
    step(8);
    echo[0] = 1'b1;
    step(20);
    en = 1'b0;
    step(20);
    echo[0] = 1'b0;
    wait_mv(50, ok);
    n_total++; if (!ok || mv_id !== 1'b0 || mv_err !== 2'd0 || mv_us < 16'd9 || mv_us > 16'd11)
      $display("FAIL endrop_result: got ok=%0d id=%0d us=%0d err=%0d want 1/0/9..11/0", ok, mv_id, mv_us, mv_err); else n_pass++;
    wait_idle(200, ok);
    n_total++; if (!ok || busy_fall_cyc - mv_cyc != 120)
      $display("FAIL endrop_idle: got %0d cycles want 120", busy_fall_cyc - mv_cyc); else n_pass++;
    r1 = rise_count[1];
    step(30);
    n_total++; if (rise_count[1] != r1 || busy !== 1'b0)
      $display("FAIL endrop_stays_idle: got busy=%b trig1_pulses=%0d want 0/0", busy, rise_count[1] - r1); else n_pass++;
    en = 1'b1;
    wait_rise(1, 10, ok);
    n_total++; if (!ok || trig !== 2'b10)
      $display("FAIL endrop_resume: got trig=%b want 10", trig); else n_pass++;
  endtask

  task automatic test_fall_zero();
    bit ok;
    wait_fall(1, 100, ok);
    step(8);
    echo[1] = 1'b1;
    step(2);
    echo[1] = 1'b0;
    wait_mv(50, ok);
    n_total++; if (!ok || mv_us !== 16'd0 || mv_err !== 2'd0 || mv_id !== 1'b1)
      $display("FAIL fall_zero: got id=%0d us=%0d err=%0d want 1/0/0", mv_id, mv_us, mv_err); else n_pass++;
  endtask

  task automatic test_reset_mid_trig();
    bit ok;
    int snap;
    wait_rise(0, 200, ok);
    wait_mv(300, ok);
    wait_rise(1, 200, ok);
    step(10);
    snap = mv_count;
    Rst = 1'b1;
    step(1);
    n_total++; if (trig !== 2'b00 || busy !== 1'b0)
      $display("FAIL rst_trig_clear: got trig=%b busy=%b want 00/0", trig, busy); else n_pass++;
    n_total++; if (meas_err !== 2'd0)
      $display("FAIL rst_err_clear: got %0d want 0", meas_err); else n_pass++;
    step(2);
    Rst = 1'b0;
    wait_rise(0, 10, ok);
    n_total++; if (!ok || trig !== 2'b01)
      $display("FAIL rst_restart_sensor0: got trig=%b want 01", trig); else n_pass++;
    n_total++; if (mv_count != snap)
      $display("FAIL rst_no_strobe: got %0d strobes want 0", mv_count - snap); else n_pass++;
  endtask

  initial begin
    int r0;
    test_reset();
    test_normal();
    test_no_echo();
    test_overrange(r0);
    test_stuck(r0);
    test_back_to_back();
    test_en_drop();
    test_fall_zero();
    test_reset_mid_trig();
    n_total++; if (multi_cnt != 0)
      $display("FAIL trig_onehot: got %0d multi-hot cycles want 0", multi_cnt); else n_pass++;
    en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hc_sr_scheduler.md
Name: hc_sr_scheduler

Overview:
- Round-robin sequencer that shares one timing and measurement datapath among NUM_SENS HC-SR ultrasonic sensors.
- For each sensor in turn it:
  - issues the trigger pulse;
  - times the echo pulse in microseconds;
  - reports one result with a status code;
  - waits a guard interval so the next sensor does not receive cross-talk.
- Sits between the sensor pins and the distance-conversion/display logic. It replaces per-sensor trig/echo drivers when more than one sensor is fitted.

Parameters:
- CLK_FREQ, 50_000_000, Clk frequency in Hz; DIV = CLK_FREQ/1_000_000 Clk cycles per µs tick (integer, >=2).
- NUM_SENS, 4, number of sensors (2..8); IDW = clog2(NUM_SENS).
- TRIG_US, 10, trigger pulse width in µs.
- RISE_TO_US, 1000, maximum wait from trigger end to echo rise.
- ECHO_MAX_US, 38000, echo width limit; must be < 65535.
- GUARD_US, 60000, quiet time after each slot, before the next sensor.

Ports:
- Clk  in  1  system clock.
- Rst  in  1  synchronous reset, active-high.
- en  in  1  1 = run the scan continuously; 0 = finish the current slot, then idle.
- echo  in  NUM_SENS  raw echo pins, asynchronous.
- trig  out  NUM_SENS  trigger pins, one-hot or all zero.
- busy  out  1  high in every state except IDLE.
- meas_valid  out  1  one-cycle result strobe.
- meas_id  out  IDW  sensor index of the result.
- meas_us  out  16  echo high time in whole µs.
- meas_err  out  2  0 = ok, 1 = no echo (rise timeout), 2 = overrange, 3 = echo stuck high at slot start.

Behaviour:
- Reset, on the Clk edge with Rst = 1:
  - state = IDLE, slot index = 0;
  - trig = 0, busy = 0, meas_valid = 0, meas_id = 0, meas_us = 0, meas_err = 0;
  - synchroniser flops and counters cleared.
  - Rst mid-slot aborts the slot: no meas_valid is emitted for it, and trig drops on that edge.
- Echo synchroniser: 2 flops per bit. The scheduler looks only at the synced bit of the current slot, so echo edges are seen 2 cycles late.
- µs tick:
  - The prescaler counts 0..DIV-1 and asserts a tick at DIV-1.
  - The prescaler and the µs counter both restart to 0 on every state entry, so each state's duration is exact in Clk cycles.
- States:
  - IDLE: if en = 1, go to TRIG on the next cycle.
  - TRIG:
    - If synced echo[idx] = 1 on entry, emit err = 3 and go to GUARD; trig stays 0.
    - Otherwise trig[idx] = 1 for exactly TRIG_US*DIV cycles, then go to WAIT_RISE.
  - WAIT_RISE:
    - On a synced rise, go to MEASURE.
    - If RISE_TO_US ticks elapse with no rise, emit err = 1 and go to GUARD.
  - MEASURE:
    - The µs counter increments on each tick while the synced echo is high.
    - On the synced fall, emit ok with meas_us = counter (partial µs truncated), then go to GUARD.
    - If the counter reaches ECHO_MAX_US while echo is still high, emit err = 2 with meas_us = ECHO_MAX_US, then go to GUARD.
  - GUARD:
    - Wait GUARD_US ticks, then advance idx, wrapping NUM_SENS-1 -> 0.
    - Then go to TRIG if en = 1, else go to IDLE.
- Result emission:
  - Exactly one meas_valid per slot, registered in the cycle the state leaves TRIG, WAIT_RISE or MEASURE.
  - meas_id, meas_us and meas_err update in that same cycle and hold until the next strobe.
- The scheduler drives exactly one trig bit at a time, and only in TRIG. Echo activity on non-current sensors is ignored.
- en is sampled only in IDLE and at the end of GUARD. Deasserting en mid-slot completes the slot, including its result and guard. Slot idx is retained across IDLE.
- A rise and a fall within the same µs still count: a fall at counter = 0 reports meas_us = 0, err = 0.

Test Plan:
Bench parameters for every case unless stated: CLK_FREQ = 4_000_000 (DIV = 4), NUM_SENS = 2, TRIG_US = 10, RISE_TO_US = 20, ECHO_MAX_US = 100, GUARD_US = 30.
- Normal slot: en = 1; echo[0] rises 5 µs after trig falls and stays high 37 µs -> trig[0] high exactly 40 cycles; meas_valid with id = 0, us = 37 (±1), err = 0.
- No echo: echo[1] held 0 -> meas_valid 80 cycles after trig[1] falls, with id = 1, err = 1; next slot triggers sensor 0 after 120 guard cycles.
- Overrange: echo[0] held high 200 µs after trig -> err = 2, us = 100; no second trig until guard expires.
- Stuck echo: echo[0] = 1 before the slot starts -> trig stays 0; err = 3, id = 0; scan proceeds to sensor 1.
- en drop mid-MEASURE: the result is still emitted, then GUARD, then IDLE with busy = 0; re-asserting en triggers sensor 1 next.
- Reset mid-TRIG: trig clears on the Rst edge; no meas_valid; after release with en = 1, the first trig is on sensor 0.
